alu_multicycle: RTL and testbench

//  Parametrised, registered ALU with a valid/ready handshake on both sides.

---
 rtl/alu_multicycle_if.sv | 26 ++
 rtl/alu_multicycle.sv | 207 ++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_multicycle_if.sv
// Request/result handshake bundle for alu_multicycle.
// The slave modport is the ALU side; the master modport is the issuer/writeback side.
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic [3:0]       ctrl_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  logic             ovf_o;

  modport slave (
    input  valid_i, src1_i, src2_i, ctrl_i, ready_i,
    output ready_o, valid_o, result_o, zero_o, ovf_o
  );

  modport master (
    output valid_i, src1_i, src2_i, ctrl_i, ready_i,
    input  ready_o, valid_o, result_o, zero_o, ovf_o
  );
endinterface

// File: rtl/alu_multicycle.sv
// Registered ALU with valid/ready handshakes; MUL iterates one bit per cycle.
// Defining ALU_DIV_EN adds a restoring divider (DIVU/REMU) sharing the BUSY iteration.
//
// state | meaning
// IDLE  | ready_o high, waiting for a request
// BUSY  | iterating MUL/DIVU/REMU, one bit per cycle
// DONE  | result presented, held until ready_i
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input logic             clk_i,
  input logic             rst_i,
  alu_multicycle_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;
`ifdef ALU_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
`ifdef ALU_DIV_EN
  logic [3:0]       op_q, op_d;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_sub;
`endif

  logic             accept;
  logic             multi_op;
  logic [WIDTH-1:0] sum, diff, fast_res;
  logic             fast_ovf;
  logic [WIDTH-1:0] step_acc, step_a, step_b, step_res;

  assign accept = bus.valid_i & bus.ready_o;

  always_comb begin
    multi_op = (bus.ctrl_i == OP_MUL);
`ifdef ALU_DIV_EN
    multi_op = multi_op | (bus.ctrl_i == OP_DIVU) | (bus.ctrl_i == OP_REMU);
`endif
  end

  always_comb begin
    sum      = bus.src1_i + bus.src2_i;
    diff     = bus.src1_i - bus.src2_i;
    fast_res = '0;
    fast_ovf = 1'b0;
    case (bus.ctrl_i)
      OP_AND:  fast_res = bus.src1_i & bus.src2_i;
      OP_OR:   fast_res = bus.src1_i | bus.src2_i;
      OP_ADD: begin
        fast_res = sum;
        fast_ovf = (bus.src1_i[WIDTH-1] == bus.src2_i[WIDTH-1]) &&
                   (sum[WIDTH-1] != bus.src1_i[WIDTH-1]);
      end
      OP_SLTU: fast_res = {{(WIDTH-1){1'b0}}, (bus.src1_i < bus.src2_i)};
      OP_SUB: begin
        fast_res = diff;
        fast_ovf = (bus.src1_i[WIDTH-1] != bus.src2_i[WIDTH-1]) &&
                   (diff[WIDTH-1] != bus.src1_i[WIDTH-1]);
      end
      OP_SLT:  fast_res = {{(WIDTH-1){1'b0}}, ($signed(bus.src1_i) < $signed(bus.src2_i))};
      OP_NOR:  fast_res = ~(bus.src1_i | bus.src2_i);
      OP_NAND: fast_res = ~(bus.src1_i & bus.src2_i);
      default: fast_res = '0;
    endcase
  end

  // One iteration: MUL adds the shifted multiplicand per multiplier bit;
  // the divider shifts the dividend into the remainder and subtracts when it fits.
  always_comb begin
    step_acc = acc_q;
    step_a   = opa_q << 1;
    step_b   = opb_q >> 1;
    if (opb_q[0]) step_acc = acc_q + opa_q;
    step_res = step_acc;
`ifdef ALU_DIV_EN
    rem_shift = {acc_q, opa_q[WIDTH-1]};
    rem_sub   = rem_shift[WIDTH-1:0] - opb_q;
    if (op_q != OP_MUL) begin
      step_b = opb_q;
      step_a = {opa_q[WIDTH-2:0], 1'b0};
      if (rem_shift >= {1'b0, opb_q}) begin
        step_acc  = rem_sub;
        step_a[0] = 1'b1;
      end else begin
        step_acc = rem_shift[WIDTH-1:0];
      end
      step_res = (op_q == OP_DIVU) ? step_a : step_acc;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    valid_d  = valid_q;
`ifdef ALU_DIV_EN
    op_d     = op_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (multi_op) begin
            state_d = BUSY;
            cnt_d   = CNT_W'(WIDTH - 1);
            acc_d   = '0;
            opa_d   = bus.src1_i;
            opb_d   = bus.src2_i;
`ifdef ALU_DIV_EN
            op_d    = bus.ctrl_i;
`endif
          end else begin
            state_d  = DONE;
            result_d = fast_res;
            zero_d   = (fast_res == '0);
            ovf_d    = fast_ovf;
            valid_d  = 1'b1;
          end
        end
      end
      BUSY: begin
        acc_d = step_acc;
        opa_d = step_a;
        opb_d = step_b;
        if (cnt_q == '0) begin
          state_d  = DONE;
          result_d = step_res;
          zero_d   = (step_res == '0);
          ovf_d    = 1'b0;
          valid_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.ready_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
`ifdef ALU_DIV_EN
      op_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
`ifdef ALU_DIV_EN
      op_q     <= op_d;
`endif
    end
  end

  assign bus.ready_o  = (state_q == IDLE) & ~rst_i;
  assign bus.valid_o  = valid_q;
  assign bus.result_o = result_q;
  assign bus.zero_o   = zero_q;
  assign bus.ovf_o    = ovf_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=32) against a plain-arithmetic reference.
module tb_alu_multicycle;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  alu_multicycle_if #(.WIDTH(W)) bus ();

  alu_multicycle #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic v, output int lat);
    logic [2*W-1:0] p;
    r = '0; v = 1'b0; lat = 1;
    case (op)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  begin r = a + b; v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      4'd3:  r = (a < b) ? 1 : 0;
      4'd6:  begin r = a - b; v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      4'd7:  r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'd8:  begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; r = p[W-1:0]; lat = W + 1; end
`ifdef ALU_DIV_EN
      4'd9:  begin r = (b == 0) ? {W{1'b1}} : a / b; lat = W + 1; end
      4'd10: begin r = (b == 0) ? a : a % b; lat = W + 1; end
`endif
      4'd12: r = ~(a | b);
      4'd13: r = ~(a & b);
      default: r = '0;
    endcase
  endfunction

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    @(negedge clk);
    while (bus.ready_o !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL issue_ready got=%b want=1", bus.ready_o); end
    bus.valid_i = 1'b1; bus.ctrl_i = op; bus.src1_i = a; bus.src2_i = b;
    @(posedge clk); #1;
    bus.valid_i = 1'b0; bus.ctrl_i = 4'($urandom); bus.src1_i = $urandom; bus.src2_i = $urandom;
  endtask

  task automatic wait_result(output int lat);
    lat = 1;
    while (bus.valid_o !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic handshake();
    @(negedge clk); bus.ready_i = 1'b1;
    @(posedge clk); #1; bus.ready_i = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks += 5;
    if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b want=0", bus.valid_o); end
    if (bus.result_o !== '0) begin errors++; $display("FAIL rst_result got=%h want=0", bus.result_o); end
    if (bus.zero_o !== 1'b0) begin errors++; $display("FAIL rst_zero got=%b want=0", bus.zero_o); end
    if (bus.ovf_o !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b want=0", bus.ovf_o); end
    if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready_during got=%b want=0", bus.ready_o); end
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready_after got=%b want=1", bus.ready_o); end
  endtask

  task automatic test_add_ovf();
    int lat;
    issue(4'd2, 32'h7FFF_FFFF, 32'h1);
    wait_result(lat);
    checks += 4;
    if (lat != 1) begin errors++; $display("FAIL add_lat got=%0d want=1", lat); end
    if (bus.result_o !== 32'h8000_0000) begin errors++; $display("FAIL add_result got=%h want=80000000", bus.result_o); end
    if (bus.ovf_o !== 1'b1) begin errors++; $display("FAIL add_ovf got=%b want=1", bus.ovf_o); end
    if (bus.zero_o !== 1'b0) begin errors++; $display("FAIL add_zero got=%b want=0", bus.zero_o); end
    handshake();
    checks += 2;
    if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL add_valid_drop got=%b want=0", bus.valid_o); end
    if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL add_ready_back got=%b want=1", bus.ready_o); end
  endtask

  task automatic test_compare();
    int lat;
    issue(4'd7, 32'hFFFF_FFFF, 32'h1); wait_result(lat);
    checks++;
    if (bus.result_o !== 32'h1) begin errors++; $display("FAIL slt got=%h want=1", bus.result_o); end
    handshake();
    issue(4'd3, 32'hFFFF_FFFF, 32'h1); wait_result(lat);
    checks += 2;
    if (bus.result_o !== 32'h0) begin errors++; $display("FAIL sltu got=%h want=0", bus.result_o); end
    if (bus.zero_o !== 1'b1) begin errors++; $display("FAIL sltu_zero got=%b want=1", bus.zero_o); end
    handshake();
    issue(4'd6, 32'd5, 32'd5); wait_result(lat);
    checks += 3;
    if (bus.result_o !== 32'h0) begin errors++; $display("FAIL sub got=%h want=0", bus.result_o); end
    if (bus.zero_o !== 1'b1) begin errors++; $display("FAIL sub_zero got=%b want=1", bus.zero_o); end
    if (bus.ovf_o !== 1'b0) begin errors++; $display("FAIL sub_ovf got=%b want=0", bus.ovf_o); end
    handshake();
  endtask

  task automatic test_mul();
    int lat = 1;
    int ready_seen = 0;
    issue(4'd8, 32'h0001_0000, 32'h0001_0003);
    while (bus.valid_o !== 1'b1 && lat < 100) begin
      if (bus.ready_o !== 1'b0) ready_seen++;
      @(posedge clk); #1; lat++;
    end
    if (bus.ready_o !== 1'b0) ready_seen++;
    checks += 3;
    if (lat != W + 1) begin errors++; $display("FAIL mul_lat got=%0d want=%0d", lat, W + 1); end
    if (bus.result_o !== 32'h0003_0000) begin errors++; $display("FAIL mul_result got=%h want=00030000", bus.result_o); end
    if (ready_seen != 0) begin errors++; $display("FAIL mul_ready_busy got=%0d want=0", ready_seen); end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad = 0;
    issue(4'd2, 32'd3, 32'd4); wait_result(lat);
    @(negedge clk);
    bus.valid_i = 1'b1; bus.ctrl_i = 4'd6; bus.src1_i = 32'd9; bus.src2_i = 32'd1;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.valid_o !== 1'b1 || bus.result_o !== 32'd7 || bus.ready_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_hold got=%0d bad cycles want=0", bad); end
    handshake();
    checks += 2;
    if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL bp_valid_drop got=%b want=0", bus.valid_o); end
    if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL bp_ready_back got=%b want=1", bus.ready_o); end
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    wait_result(lat);
    checks += 2;
    if (lat != 1) begin errors++; $display("FAIL bp_held_req_lat got=%0d want=1", lat); end
    if (bus.result_o !== 32'd8) begin errors++; $display("FAIL bp_held_req got=%h want=8", bus.result_o); end
    handshake();
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen = 0;
    issue(4'd1, 32'd5, 32'd0); wait_result(lat); handshake();
    issue(4'd8, 32'd1234, 32'd5678);
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks += 3;
    if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b want=0", bus.valid_o); end
    if (bus.result_o !== '0) begin errors++; $display("FAIL midrst_result got=%h want=0", bus.result_o); end
    if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL midrst_ready_during got=%b want=0", bus.ready_o); end
    @(negedge clk); rst = 1'b0; bus.ready_i = 1'b1; #1;
    checks++;
    if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready_after got=%b want=1", bus.ready_o); end
    repeat (W + 8) begin @(posedge clk); #1; if (bus.valid_o !== 1'b0) seen++; end
    bus.ready_i = 1'b0;
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midrst_ghost got=%0d want=0", seen); end
  endtask

  task automatic test_div();
    logic [3:0]   ops [4] = '{4'd9, 4'd10, 4'd9, 4'd10};
    logic [W-1:0] as  [4] = '{32'd100, 32'd100, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    logic [W-1:0] bs  [4] = '{32'd7, 32'd7, 32'd0, 32'd0};
`ifdef ALU_DIV_EN
    logic [W-1:0] exp [4] = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
    int elat = W + 1;
`else
    logic [W-1:0] exp [4] = '{32'd0, 32'd0, 32'd0, 32'd0};
    int elat = 1;
`endif
    int lat;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i]); wait_result(lat);
      checks += 3;
      if (lat != elat) begin errors++; $display("FAIL div%0d_lat got=%0d want=%0d", i, lat, elat); end
      if (bus.result_o !== exp[i]) begin errors++; $display("FAIL div%0d_result got=%h want=%h", i, bus.result_o, exp[i]); end
      if (bus.zero_o !== (exp[i] == '0)) begin errors++; $display("FAIL div%0d_zero got=%b want=%b", i, bus.zero_o, exp[i] == '0); end
      handshake();
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      4: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [3:0]   op;
    logic [W-1:0] a, b, er;
    logic         ev;
    int           elat, lat;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a = pick_operand(); b = pick_operand();
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 20));
      model(op, a, b, er, ev, elat);
      issue(op, a, b); wait_result(lat);
      checks += 4;
      if (lat != elat) begin errors++; $display("FAIL rnd%0d_lat op=%0d got=%0d want=%0d", i, op, lat, elat); end
      if (bus.result_o !== er) begin errors++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, bus.result_o, er); end
      if (bus.zero_o !== (er == '0)) begin errors++; $display("FAIL rnd%0d_zero op=%0d got=%b want=%b", i, op, bus.zero_o, er == '0); end
      if (bus.ovf_o !== ev) begin errors++; $display("FAIL rnd%0d_ovf op=%0d got=%b want=%b", i, op, bus.ovf_o, ev); end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      checks++;
      if (bus.result_o !== er) begin errors++; $display("FAIL rnd%0d_hold got=%h want=%h", i, bus.result_o, er); end
      handshake();
    end
  endtask

  initial begin
    bus.valid_i = 1'b0; bus.ready_i = 1'b0;
    bus.src1_i = '0; bus.src2_i = '0; bus.ctrl_i = '0;
    test_reset();
    test_add_ovf();
    test_compare();
    test_mul();
    test_backpressure();
    test_reset_mid();
    test_div();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
